uart_tx_fifo_engine: RTL

//  Parametrised UART transmit engine with an integrated TX FIFO. It replaces the

---
 rtl/uart_tx_fifo_engine.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_engine.sv
// rtl/uart_tx_fifo_engine.sv - UART transmitter with integrated TX FIFO; UART_TX_BREAK_EN adds brk/BREAK
module uart_tx_fifo_engine #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 19
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [DATA_W-1:0]                 din,
    input  logic                              eight,
    input  logic                              pen,
    input  logic                              ohel,
    input  logic [DIV_W-1:0]                  k,
`ifdef UART_TX_BREAK_EN
    input  logic                              brk,
`endif
    output logic                              tx_rdy,
    output logic                              tx_idle,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              ovf,
    output logic                              tx_done,
    output logic                              Tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int FW = DATA_W + 3;
    localparam int BW = $clog2(FW+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK,
        S_MARK
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                ovf_q;
    logic                done_q, done_d;
    logic [FW-1:0]       frame_q, frame_d, frame_new;
    logic [BW-1:0]       bit_idx_q, bit_idx_d, nbits_q, nbits_d, nbits_new;
    logic [DIV_W-1:0]    baud_q, baud_d, kk_q, kk_d, k_eff;
    logic                full, empty, push, pop, start, par;
    logic [DATA_W-1:0]   head;
    int                  d;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = load && !full;
    assign tx_rdy     = !full;
    assign tx_idle    = (state_q == S_IDLE) && empty;
    assign fifo_count = count_q;
    assign ovf        = ovf_q;
    assign tx_done    = done_q;
    assign k_eff      = (k == '0) ? DIV_W'(1) : k;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A load against a full FIFO is lost even if a pop frees a slot this cycle.
            if (load && full) ovf_q <= 1'b1;
        end
    end

    // Frame image: bit 0 is the start bit, all unused upper bits read as stop/idle 1s.
    always_comb begin
        d         = eight ? DATA_W : DATA_W - 1;
        head      = mem_q[rd_ptr_q];
        par       = ohel;
        frame_new = '1;
        frame_new[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < d) par = par ^ head[i];
        end
        for (int i = 1; i <= DATA_W; i++) begin
            if (i <= d) frame_new[i] = head[i-1];
        end
        for (int i = 2; i < FW; i++) begin
            if (pen && (i == d + 1)) frame_new[i] = par;
        end
        nbits_new = BW'(d + (pen ? 3 : 2));
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        nbits_d   = nbits_q;
        baud_d    = baud_q;
        kk_d      = kk_q;
        done_d    = 1'b0;
        start     = 1'b0;
        case (state_q)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (brk) begin
                    state_d = S_BREAK;
                    kk_d    = k_eff;
                end else
`endif
                if (!empty) start = 1'b1;
            end
            S_SEND: begin
                if (baud_q == kk_q - 1'b1) begin
                    baud_d = '0;
                    if (bit_idx_q == nbits_q - 1'b1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`ifdef UART_TX_BREAK_EN
                        if (brk) begin
                            state_d = S_BREAK;
                            kk_d    = k_eff;
                        end else
`endif
                        if (!empty) start = 1'b1;
                    end else begin
                        frame_d   = {1'b1, frame_q[FW-1:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                if (!brk) begin
                    state_d = S_MARK;
                    baud_d  = '0;
                end
            end
            S_MARK: begin
                if (baud_q == kk_q - 1'b1) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d   = S_SEND;
            frame_d   = frame_new;
            nbits_d   = nbits_new;
            kk_d      = k_eff;
            bit_idx_d = '0;
            baud_d    = '0;
        end
        pop = start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            frame_q   <= '1;
            bit_idx_q <= '0;
            nbits_q   <= '0;
            baud_q    <= '0;
            kk_q      <= DIV_W'(1);
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            nbits_q   <= nbits_d;
            baud_q    <= baud_d;
            kk_q      <= kk_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        Tx = 1'b1;
        case (state_q)
            S_SEND:  Tx = frame_q[0];
`ifdef UART_TX_BREAK_EN
            S_BREAK: Tx = 1'b0;
`endif
            default: Tx = 1'b1;
        endcase
    end

endmodule
